softex_slot_ctrl: RTL and testbench

SOFTEX_SLOT_CTRL -- requirements
Module: softex_slot_ctrl

---
 rtl/softex_pkg.sv | 46 ++++
 rtl/softex_slot_lookup.sv | 35 +++
 rtl/softex_slot_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_softex_slot_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softex_pkg.sv
// Shared types and constants for the SoftEx slot table controller.
package softex_pkg;

    localparam int unsigned TAG_W           = 8;
    localparam int unsigned FP_W            = 16;  // FPFORMAT_IN width
    localparam int unsigned DEN_W           = 32;  // accumulator width of the denominator
    localparam int unsigned N_SLOTS_DEFAULT = 4;

    // -inf in FPFORMAT_IN: sign=1, exponent all ones, mantissa zero
    localparam logic [FP_W-1:0] SLOT_MAX_INIT = 16'hFF80;

    typedef enum logic {
        SLOT_ALLOC = 1'b0,
        SLOT_LOAD  = 1'b1
    } slot_req_kind_e;

    typedef enum logic {
        SLOT_UPDATE = 1'b0,
        SLOT_FREE   = 1'b1
    } slot_upd_kind_e;

    typedef struct packed {
        logic [FP_W-1:0]  maximum;
        logic [DEN_W-1:0] denominator;
        logic             valid;
    } slot_t;

    typedef struct packed {
        slot_req_kind_e   op;
        logic [TAG_W-1:0] addr;
    } slot_req_op_t;

    typedef struct packed {
        slot_upd_kind_e   op;
        logic [TAG_W-1:0] addr;
        logic [FP_W-1:0]  maximum;
        logic [DEN_W-1:0] denominator;
    } slot_update_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } slot_ctrl_state_e;

endpackage

// File: rtl/softex_slot_lookup.sv
// Combinational tag match and lowest-free-entry search over the slot table.
module softex_slot_lookup
    import softex_pkg::*;
#(
    parameter int unsigned N_SLOTS = N_SLOTS_DEFAULT,
    localparam int unsigned IDX_W  = $clog2(N_SLOTS)
) (
    input  logic [N_SLOTS-1:0]            valid,
    input  logic [N_SLOTS-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]              addr,
    output logic                          hit,
    output logic [IDX_W-1:0]              hit_idx,
    output logic                          free_avail,
    output logic [IDX_W-1:0]              free_idx
);

    // Scan from the top so the lowest matching / free index is the one that sticks.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_avail = 1'b0;
        free_idx   = '0;
        for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == addr)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_avail = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/softex_slot_ctrl.sv
// Fully associative slot table with a request/response port (ALLOC/LOAD)
// and a fire-and-forget update port (UPDATE/FREE).
module softex_slot_ctrl
    import softex_pkg::*;
#(
    parameter int unsigned     N_SLOTS  = N_SLOTS_DEFAULT,
    parameter logic [FP_W-1:0] MAX_INIT = SLOT_MAX_INIT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  slot_req_op_t                 req_op_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output slot_t                        rsp_slot_o,
    output logic                         rsp_err_o,
    input  logic                         upd_valid_i,
    output logic                         upd_ready_o,
    input  slot_update_op_t              upd_op_i,
    output logic [$clog2(N_SLOTS+1)-1:0] occupancy_o,
    output logic                         busy_o
);

    localparam int unsigned IDX_W = $clog2(N_SLOTS);
    localparam int unsigned OCC_W = $clog2(N_SLOTS+1);

    // Table state
    logic [N_SLOTS-1:0]            valid_q, valid_d;
    logic [N_SLOTS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [N_SLOTS-1:0][FP_W-1:0]  max_q, max_d;
    logic [N_SLOTS-1:0][DEN_W-1:0] den_q, den_d;
    logic [OCC_W-1:0]              occupancy_q, occupancy_d;

    // Request path state
    slot_ctrl_state_e state_q;
    slot_req_op_t     req_op_q;
    slot_t            rsp_slot_q, rsp_slot_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q;
    logic             busy_q;

    logic             req_hit, req_free_avail;
    logic [IDX_W-1:0] req_hit_idx, req_free_idx;
    logic             upd_hit;
    logic [IDX_W-1:0] upd_hit_idx;
    logic             upd_free_unused;
    logic [IDX_W-1:0] upd_free_idx_unused;

    logic             req_fire, upd_fire, in_lookup;
    logic             alloc_ok, fwd;
    logic [IDX_W-1:0] alloc_idx;

    softex_slot_lookup #(
        .N_SLOTS (N_SLOTS)
    ) u_req_lookup (
        .valid      (valid_q),
        .tags       (tag_q),
        .addr       (req_op_q.addr),
        .hit        (req_hit),
        .hit_idx    (req_hit_idx),
        .free_avail (req_free_avail),
        .free_idx   (req_free_idx)
    );

    softex_slot_lookup #(
        .N_SLOTS (N_SLOTS)
    ) u_upd_lookup (
        .valid      (valid_q),
        .tags       (tag_q),
        .addr       (upd_op_i.addr),
        .hit        (upd_hit),
        .hit_idx    (upd_hit_idx),
        .free_avail (upd_free_unused),
        .free_idx   (upd_free_idx_unused)
    );

    assign req_ready_o = (state_q == IDLE) && !clear_i;
    assign upd_ready_o = !clear_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign upd_fire    = upd_valid_i && upd_ready_o;
    assign in_lookup   = (state_q == LOOKUP);

    // Allocation sees the table as it was before this cycle's FREE.
    assign alloc_ok  = in_lookup && (req_op_q.op == SLOT_ALLOC) && (req_hit || req_free_avail);
    assign alloc_idx = req_hit ? req_hit_idx : req_free_idx;
    // A LOAD hit coinciding with an update to the same entry returns the written values.
    assign fwd = in_lookup && (req_op_q.op == SLOT_LOAD) && req_hit && upd_fire && upd_hit &&
                 (upd_hit_idx == req_hit_idx);

    // Table next state: update port first, then ALLOC overrides, then clear overrides all.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        max_d   = max_q;
        den_d   = den_q;
        if (upd_fire && upd_hit) begin
            if (upd_op_i.op == SLOT_UPDATE) begin
                max_d[upd_hit_idx] = upd_op_i.maximum;
                den_d[upd_hit_idx] = upd_op_i.denominator;
            end else begin
                valid_d[upd_hit_idx] = 1'b0;
            end
        end
        if (alloc_ok) begin
            valid_d[alloc_idx] = 1'b1;
            tag_d[alloc_idx]   = req_op_q.addr;
            max_d[alloc_idx]   = MAX_INIT;
            den_d[alloc_idx]   = '0;
        end
        if (clear_i) begin
            valid_d = '0;
        end
    end

    // Population count of the next valid vector keeps occupancy in step with the table.
    always_comb begin
        occupancy_d = '0;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
        end
    end

    // Response payload computed during LOOKUP.
    always_comb begin
        rsp_slot_d = '0;
        rsp_err_d  = 1'b0;
        if (req_op_q.op == SLOT_LOAD) begin
            if (fwd) begin
                if (upd_op_i.op == SLOT_UPDATE) begin
                    rsp_slot_d.maximum     = upd_op_i.maximum;
                    rsp_slot_d.denominator = upd_op_i.denominator;
                    rsp_slot_d.valid       = 1'b1;
                end
            end else if (req_hit) begin
                rsp_slot_d.maximum     = max_q[req_hit_idx];
                rsp_slot_d.denominator = den_q[req_hit_idx];
                rsp_slot_d.valid       = 1'b1;
            end
        end else if (alloc_ok) begin
            rsp_slot_d.maximum = MAX_INIT;
            rsp_slot_d.valid   = 1'b1;
        end else begin
            rsp_err_d = 1'b1;
        end
    end

    // Slot table registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            tag_q       <= '0;
            max_q       <= '0;
            den_q       <= '0;
            occupancy_q <= '0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            max_q       <= max_d;
            den_q       <= den_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_op_q    <= '0;
            rsp_slot_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        req_op_q <= req_op_i;
                        busy_q   <= 1'b1;
                        state_q  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    rsp_slot_q  <= rsp_slot_d;
                    rsp_err_q   <= rsp_err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_slot_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_slot_o  = rsp_slot_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign occupancy_o = occupancy_q;

endmodule

// File: tb/tb_softex_slot_ctrl.sv
// Bench for softex_slot_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a table-level reference model.
module tb_softex_slot_ctrl;
    import softex_pkg::*;

    localparam int NS = 4;

    logic            clk, rst, clear;
    logic            req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic            upd_valid, upd_ready, busy;
    slot_req_op_t    req_op;
    slot_update_op_t upd_op;
    slot_t           rsp_slot;
    logic [2:0]      occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    softex_slot_ctrl #(
        .N_SLOTS  (NS),
        .MAX_INIT (16'hFF80)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_slot_o  (rsp_slot),
        .rsp_err_o   (rsp_err),
        .upd_valid_i (upd_valid),
        .upd_ready_o (upd_ready),
        .upd_op_i    (upd_op),
        .occupancy_o (occupancy),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: table as plain arrays ----------------
    bit          m_valid[NS], n_valid[NS];
    logic [7:0]  m_tag[NS],   n_tag[NS];
    logic [15:0] m_max[NS],   n_max[NS];
    logic [31:0] m_den[NS],   n_den[NS];
    int          m_phase, n_phase;  // 0 idle, 1 request accepted last edge, 2 response pending
    slot_req_op_t m_req, n_req;
    slot_t       m_rsp, n_rsp;
    bit          m_err, n_err;

    function automatic int m_find(input logic [7:0] a);
        for (int i = 0; i < NS; i++) if (m_valid[i] && m_tag[i] == a) return i;
        return -1;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NS; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_max[i] = '0; m_den[i] = '0;
        end
        m_phase = 0; m_req = '0; m_rsp = '0; m_err = 0;
    endtask

    task automatic model_next();
        int k, slot;
        bit rf, uf;
        n_valid = m_valid; n_tag = m_tag; n_max = m_max; n_den = m_den;
        n_phase = m_phase; n_req = m_req; n_rsp = m_rsp; n_err = m_err;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                n_valid[i] = 0; n_tag[i] = '0; n_max[i] = '0; n_den[i] = '0;
            end
            n_phase = 0; n_rsp = '0; n_err = 0;
            return;
        end
        rf   = req_valid && (m_phase == 0) && !clear;
        uf   = upd_valid && !clear;
        slot = -1;
        if (m_phase == 1) begin
            k = m_find(m_req.addr);
            n_rsp = '0;
            n_err = 0;
            if (m_req.op == SLOT_LOAD) begin
                if (k >= 0) begin
                    n_rsp.maximum = m_max[k]; n_rsp.denominator = m_den[k]; n_rsp.valid = 1'b1;
                    if (uf && upd_op.addr == m_req.addr) begin
                        if (upd_op.op == SLOT_UPDATE) begin
                            n_rsp.maximum = upd_op.maximum; n_rsp.denominator = upd_op.denominator;
                        end else begin
                            n_rsp = '0;
                        end
                    end
                end
            end else begin
                slot = (k >= 0) ? k : m_first_free();
                if (slot < 0) n_err = 1;
                else begin
                    n_rsp.maximum = 16'hFF80; n_rsp.valid = 1'b1;
                end
            end
        end
        if (uf) begin
            k = m_find(upd_op.addr);
            if (k >= 0) begin
                if (upd_op.op == SLOT_UPDATE) begin
                    n_max[k] = upd_op.maximum; n_den[k] = upd_op.denominator;
                end else n_valid[k] = 0;
            end
        end
        if (slot >= 0) begin
            n_valid[slot] = 1; n_tag[slot] = m_req.addr; n_max[slot] = 16'hFF80; n_den[slot] = '0;
        end
        if (clear) for (int i = 0; i < NS; i++) n_valid[i] = 0;
        case (m_phase)
            0: if (rf) begin n_phase = 1; n_req = req_op; end
            1: n_phase = 2;
            default: if (rsp_ready) n_phase = 0;
        endcase
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        m_valid = n_valid; m_tag = n_tag; m_max = n_max; m_den = n_den;
        m_phase = n_phase; m_req = n_req; m_rsp = n_rsp; m_err = n_err;
        #1;
    endtask

    // Every-cycle comparison against the model, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_req_ready", 64'(req_ready), 64'((m_phase == 0) && !clear));
            chk("m_upd_ready", 64'(upd_ready), 64'(!clear));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
            chk("m_busy", 64'(busy), 64'(m_phase != 0));
            chk("m_occupancy", 64'(occupancy), 64'(m_count()));
            if (m_phase == 2) begin
                chk("m_rsp_slot", 64'(rsp_slot), 64'(m_rsp));
                chk("m_rsp_err", 64'(rsp_err), 64'(m_err));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_req(input slot_req_kind_e op, input logic [7:0] addr,
                          output slot_t rsp, output logic err, output int lat);
        lat = 0;
        req_op.op = op; req_op.addr = addr; req_valid = 1; rsp_ready = 1;
        tick();
        req_valid = 0;
        while (!rsp_valid && lat < 8) begin tick(); lat++; end
        chk("rsp_arrived", 64'(rsp_valid), 64'd1);
        rsp = rsp_slot; err = rsp_err;
        tick();
    endtask

    task automatic do_upd(input slot_upd_kind_e op, input logic [7:0] addr,
                          input logic [15:0] mx, input logic [31:0] dn);
        upd_op.op = op; upd_op.addr = addr; upd_op.maximum = mx; upd_op.denominator = dn;
        upd_valid = 1;
        tick();
        upd_valid = 0;
    endtask

    // Issue a request and stop in LOOKUP so a concurrent update can be placed there.
    task automatic issue(input slot_req_kind_e op, input logic [7:0] addr);
        req_op.op = op; req_op.addr = addr; req_valid = 1; rsp_ready = 1;
        tick();
        req_valid = 0;
    endtask

    task automatic do_clear();
        clear = 1; tick(); clear = 0;
    endtask

    slot_t r;
    logic  e;
    int    lat;

    initial begin
        rst = 1; clear = 0; req_valid = 0; rsp_ready = 1; upd_valid = 0;
        req_op = '0; upd_op = '0;
        m_reset();
        cmp_en = 1;
        @(posedge clk); #1;
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        rst = 0;
        tick();
        chk("reset_req_ready", 64'(req_ready), 64'd1);

        // ALLOC into empty table
        do_req(SLOT_ALLOC, 8'h12, r, e, lat);
        chk("alloc_latency", 64'(lat), 64'd1);
        chk("alloc_valid", 64'(r.valid), 64'd1);
        chk("alloc_max", 64'(r.maximum), 64'hFF80);
        chk("alloc_den", 64'(r.denominator), 64'd0);
        chk("alloc_err", 64'(e), 64'd0);
        chk("alloc_occ", 64'(occupancy), 64'd1);

        // UPDATE then LOAD hit / LOAD miss
        do_upd(SLOT_UPDATE, 8'h12, 16'h3F80, 32'h4000_0000);
        do_req(SLOT_LOAD, 8'h12, r, e, lat);
        chk("load_max", 64'(r.maximum), 64'h3F80);
        chk("load_den", 64'(r.denominator), 64'h4000_0000);
        chk("load_valid", 64'(r.valid), 64'd1);
        do_req(SLOT_LOAD, 8'h34, r, e, lat);
        chk("load_miss_valid", 64'(r.valid), 64'd0);
        chk("load_miss_max", 64'(r.maximum), 64'd0);

        // Fill table, overflow, free and reuse lowest entry
        do_clear();
        for (int i = 1; i <= 4; i++) do_req(SLOT_ALLOC, 8'(i), r, e, lat);
        do_req(SLOT_ALLOC, 8'h05, r, e, lat);
        chk("full_err", 64'(e), 64'd1);
        chk("full_valid", 64'(r.valid), 64'd0);
        chk("full_occ", 64'(occupancy), 64'd4);
        do_upd(SLOT_FREE, 8'h02, 16'h0, 32'h0);
        do_req(SLOT_ALLOC, 8'h05, r, e, lat);
        chk("reuse_err", 64'(e), 64'd0);
        chk("reuse_tag_entry1", 64'(dut.tag_q[1]), 64'h05);
        chk("reuse_valid_entry1", 64'(dut.valid_q[1]), 64'd1);

        // FREE alongside ALLOC-miss on a full table: freed entry not visible
        issue(SLOT_ALLOC, 8'h06);
        upd_op.op = SLOT_FREE; upd_op.addr = 8'h01; upd_valid = 1;
        tick();
        upd_valid = 0;
        chk("free_alloc_race_err", 64'(rsp_err), 64'd1);
        tick();
        chk("free_alloc_race_occ", 64'(occupancy), 64'd3);

        // Forwarding and ALLOC-vs-FREE collision
        do_clear();
        do_req(SLOT_ALLOC, 8'h12, r, e, lat);
        issue(SLOT_LOAD, 8'h12);
        upd_op.op = SLOT_UPDATE; upd_op.addr = 8'h12;
        upd_op.maximum = 16'h4000; upd_op.denominator = 32'h1;
        upd_valid = 1;
        tick();
        upd_valid = 0;
        chk("fwd_max", 64'(rsp_slot.maximum), 64'h4000);
        chk("fwd_den", 64'(rsp_slot.denominator), 64'h1);
        tick();
        issue(SLOT_ALLOC, 8'h12);
        upd_op.op = SLOT_FREE; upd_op.addr = 8'h12; upd_valid = 1;
        tick();
        upd_valid = 0;
        chk("alloc_wins_max", 64'(rsp_slot.maximum), 64'hFF80);
        tick();
        do_req(SLOT_LOAD, 8'h12, r, e, lat);
        chk("alloc_wins_valid", 64'(r.valid), 64'd1);
        chk("alloc_wins_stored_max", 64'(r.maximum), 64'hFF80);

        // Back-pressure with clear landing during RESP
        do_upd(SLOT_UPDATE, 8'h12, 16'h3F80, 32'h7);
        rsp_ready = 0;
        issue(SLOT_LOAD, 8'h12);
        rsp_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall_max", 64'(rsp_slot.maximum), 64'h3F80);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            clear = (i == 2);
            tick();
        end
        clear = 0;
        chk("stall_after_clear_max", 64'(rsp_slot.maximum), 64'h3F80);
        chk("stall_after_clear_occ", 64'(occupancy), 64'd0);
        rsp_ready = 1;
        tick();
        chk("stall_released", 64'(rsp_valid), 64'd0);

        // Reset while a request sits in LOOKUP
        do_req(SLOT_ALLOC, 8'h33, r, e, lat);
        issue(SLOT_ALLOC, 8'h40);
        rst = 1;
        m_reset();
        #1;
        chk("rst_lookup_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_lookup_occ", 64'(occupancy), 64'd0);
        tick();
        tick();
        rst = 0;
        tick();
        chk("rst_release_req_ready", 64'(req_ready), 64'd1);
        chk("rst_release_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_release_occ", 64'(occupancy), 64'd0);

        // Randomized traffic on a small tag space to force hits and collisions
        for (int c = 0; c < 3000; c++) begin
            clear          = ($urandom_range(0, 40) == 0);
            req_valid      = ($urandom_range(0, 1) == 1);
            req_op.op      = slot_req_kind_e'($urandom_range(0, 1));
            req_op.addr    = 8'($urandom_range(0, 6));
            rsp_ready      = ($urandom_range(0, 3) != 0);
            upd_valid      = ($urandom_range(0, 1) == 1);
            upd_op.op      = slot_upd_kind_e'($urandom_range(0, 3) == 0);
            upd_op.addr    = 8'($urandom_range(0, 6));
            upd_op.maximum = 16'($urandom);
            upd_op.denominator = $urandom;
            tick();
        end

        clear = 0; req_valid = 0; upd_valid = 0; rsp_ready = 1;
        tick();
        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
